// File: rtl/tlb_unit_if.sv
// CP0 / pipeline side of the TLB: two translation search ports plus TLBWI, TLBR and TLBP.
// The master modport belongs to the requester side; the TLB itself uses the slave modport.
interface tlb_unit_if #(
   parameter int unsigned IDXW = 4,
   parameter int unsigned EW   = 78
);
   // Port 0: instruction fetch
   logic            s0_req;
   logic [31:0]     s0_vaddr;
   logic [7:0]      s0_asid;
   logic            s0_rsp;
   logic            s0_found;
   logic [IDXW-1:0] s0_index;
   logic [19:0]     s0_pfn;
   logic [2:0]      s0_c;
   logic            s0_d;
   logic            s0_v;

   // Port 1: data access
   logic            s1_req;
   logic [31:0]     s1_vaddr;
   logic [7:0]      s1_asid;
   logic            s1_rsp;
   logic            s1_found;
   logic [IDXW-1:0] s1_index;
   logic [19:0]     s1_pfn;
   logic [2:0]      s1_c;
   logic            s1_d;
   logic            s1_v;

   // TLBWI
   logic            tlbwi_we;
   logic [IDXW-1:0] tlbwi_index;
   logic [EW-1:0]   tlbwi_entry;

   // TLBR
   logic            tlbr_req;
   logic [IDXW-1:0] tlbr_index;
   logic            tlbr_wen;
   logic [EW-1:0]   tlbr_entry;

   // TLBP
   logic            tlbp_req;
   logic [31:0]     tlbp_entryhi;
   logic            tlbp_busy;
   logic            tlbp_done;
   logic [31:0]     tlbp_index;

   modport master (
      output s0_req, s0_vaddr, s0_asid,
      input  s0_rsp, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      output s1_req, s1_vaddr, s1_asid,
      input  s1_rsp, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      output tlbwi_we, tlbwi_index, tlbwi_entry,
      output tlbr_req, tlbr_index,
      input  tlbr_wen, tlbr_entry,
      output tlbp_req, tlbp_entryhi,
      input  tlbp_busy, tlbp_done, tlbp_index
   );

   modport slave (
      input  s0_req, s0_vaddr, s0_asid,
      output s0_rsp, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      input  s1_req, s1_vaddr, s1_asid,
      output s1_rsp, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      input  tlbwi_we, tlbwi_index, tlbwi_entry,
      input  tlbr_req, tlbr_index,
      output tlbr_wen, tlbr_entry,
      input  tlbp_req, tlbp_entryhi,
      output tlbp_busy, tlbp_done, tlbp_index
   );
endinterface

// File: rtl/tlb_unit.sv
// 16-entry fully associative MIPS32 TLB, fixed 4 KB pages: two registered search ports,
// TLBWI write, TLBR read and a three-state TLBP probe engine.
module tlb_unit #(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IDXW   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   tlb_unit_if.slave   tlb
);

   localparam int unsigned EW       = 78;
   localparam int unsigned VPN2W    = 19;
   localparam int unsigned ASIDW    = 8;
   localparam int unsigned HALFW    = 25;
   localparam int unsigned VPN2_LSB = 59;
   localparam int unsigned ASID_LSB = 51;
   localparam int unsigned G_BIT    = 50;
   localparam int unsigned EVEN_LSB = 25;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_CMP  = 2'd1,
      P_DONE = 2'd2
   } pstate_t;

   logic [EW-1:0]     tlb_mem [TLBNUM];
   pstate_t           pstate;
   logic [VPN2W-1:0]  probe_vpn2;
   logic [ASIDW-1:0]  probe_asid;

   logic [TLBNUM-1:0] s0_hit_c, s1_hit_c, p_hit_c;
   logic [IDXW-1:0]   s0_idx_c, s1_idx_c, p_idx_c;
   logic              s0_found_c, s1_found_c, p_found_c;
   logic [HALFW-1:0]  s0_half_c, s1_half_c;

   function automatic logic entry_match(input logic [EW-1:0]    e,
                                        input logic [VPN2W-1:0] vpn2,
                                        input logic [ASIDW-1:0] asid);
      return (e[VPN2_LSB +: VPN2W] == vpn2) &&
             (e[G_BIT] || (e[ASID_LSB +: ASIDW] == asid));
   endfunction

   // Lowest set bit wins; returns 0 when nothing hits.
   function automatic logic [IDXW-1:0] first_hit(input logic [TLBNUM-1:0] hits);
      logic [IDXW-1:0] idx;
      logic            seen;
      idx  = '0;
      seen = 1'b0;
      for (int unsigned i = 0; i < TLBNUM; i++) begin
         if (hits[i] && !seen) begin
            idx  = IDXW'(i);
            seen = 1'b1;
         end
      end
      return idx;
   endfunction

   // Odd page half {PFN1,C1,D1,V1} sits in the low bits, even half directly above it.
   function automatic logic [HALFW-1:0] sel_half(input logic [EW-1:0] e, input logic odd);
      return odd ? e[HALFW-1:0] : e[EVEN_LSB +: HALFW];
   endfunction

   always_comb begin
      s0_hit_c = '0;
      s1_hit_c = '0;
      p_hit_c  = '0;
      for (int unsigned i = 0; i < TLBNUM; i++) begin
         s0_hit_c[i] = entry_match(tlb_mem[i], tlb.s0_vaddr[31:13], tlb.s0_asid);
         s1_hit_c[i] = entry_match(tlb_mem[i], tlb.s1_vaddr[31:13], tlb.s1_asid);
         p_hit_c[i]  = entry_match(tlb_mem[i], probe_vpn2, probe_asid);
      end
      s0_found_c = |s0_hit_c;
      s1_found_c = |s1_hit_c;
      p_found_c  = |p_hit_c;
      s0_idx_c   = first_hit(s0_hit_c);
      s1_idx_c   = first_hit(s1_hit_c);
      p_idx_c    = first_hit(p_hit_c);
      s0_half_c  = sel_half(tlb_mem[s0_idx_c], tlb.s0_vaddr[12]);
      s1_half_c  = sel_half(tlb_mem[s1_idx_c], tlb.s1_vaddr[12]);
   end

   // Page offsets and EntryHi bits [12:8] take no part in matching.
   logic unused_bits;
   assign unused_bits = ^{tlb.s0_vaddr[11:0], tlb.s1_vaddr[11:0], tlb.tlbp_entryhi[12:8]};

   // Entry storage; same-cycle compares and reads see the pre-write contents.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < TLBNUM; i++) begin
            tlb_mem[i] <= '0;
         end
      end else if (tlb.tlbwi_we) begin
         tlb_mem[tlb.tlbwi_index] <= tlb.tlbwi_entry;
      end
   end

   // Search port 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tlb.s0_rsp   <= 1'b0;
         tlb.s0_found <= 1'b0;
         tlb.s0_index <= '0;
         {tlb.s0_pfn, tlb.s0_c, tlb.s0_d, tlb.s0_v} <= '0;
      end else begin
         tlb.s0_rsp <= tlb.s0_req;
         if (tlb.s0_req) begin
            tlb.s0_found <= s0_found_c;
            tlb.s0_index <= s0_found_c ? s0_idx_c : '0;
            {tlb.s0_pfn, tlb.s0_c, tlb.s0_d, tlb.s0_v} <= s0_found_c ? s0_half_c : '0;
         end
      end
   end

   // Search port 1
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tlb.s1_rsp   <= 1'b0;
         tlb.s1_found <= 1'b0;
         tlb.s1_index <= '0;
         {tlb.s1_pfn, tlb.s1_c, tlb.s1_d, tlb.s1_v} <= '0;
      end else begin
         tlb.s1_rsp <= tlb.s1_req;
         if (tlb.s1_req) begin
            tlb.s1_found <= s1_found_c;
            tlb.s1_index <= s1_found_c ? s1_idx_c : '0;
            {tlb.s1_pfn, tlb.s1_c, tlb.s1_d, tlb.s1_v} <= s1_found_c ? s1_half_c : '0;
         end
      end
   end

   // TLBR
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tlb.tlbr_wen   <= 1'b0;
         tlb.tlbr_entry <= '0;
      end else begin
         tlb.tlbr_wen <= tlb.tlbr_req;
         if (tlb.tlbr_req) begin
            tlb.tlbr_entry <= tlb_mem[tlb.tlbr_index];
         end
      end
   end

   // TLBP engine: IDLE latches EntryHi, CMP registers the result, DONE pulses tlbp_done.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pstate         <= P_IDLE;
         probe_vpn2     <= '0;
         probe_asid     <= '0;
         tlb.tlbp_busy  <= 1'b0;
         tlb.tlbp_done  <= 1'b0;
         tlb.tlbp_index <= '0;
      end else begin
         tlb.tlbp_done <= 1'b0;
         case (pstate)
            P_IDLE: begin
               if (tlb.tlbp_req) begin
                  probe_vpn2    <= tlb.tlbp_entryhi[31:13];
                  probe_asid    <= tlb.tlbp_entryhi[7:0];
                  tlb.tlbp_busy <= 1'b1;
                  pstate        <= P_CMP;
               end
            end
            P_CMP: begin
               tlb.tlbp_done  <= 1'b1;
               tlb.tlbp_busy  <= 1'b0;
               tlb.tlbp_index <= {~p_found_c, {(31-IDXW){1'b0}}, p_found_c ? p_idx_c : IDXW'(0)};
               pstate         <= P_DONE;
            end
            P_DONE: begin
               pstate <= P_IDLE;
            end
            default: begin
               pstate <= P_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed scenarios then randomized traffic,
// all checked against a field-level table model.
module tb_tlb_unit;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   tlb_unit_if bus ();

   tlb_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .tlb    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } ent_t;

   int total = 0;
   int bad   = 0;

   ent_t        tbl [16];
   logic [29:0] last0, last1;
   logic [77:0] last_rd;
   logic [31:0] last_pidx;

   function automatic ent_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                               input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                               input logic v0, input logic [19:0] pfn1, input logic [2:0] c1,
                               input logic d1, input logic v1);
      ent_t e;
      e.vpn2 = vpn2; e.asid = asid; e.g = g;
      e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
      e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
      return e;
   endfunction

   function automatic logic [77:0] pack(input ent_t e);
      return {e.vpn2, e.asid, e.g, e.pfn0, e.c0, e.d0, e.v0, e.pfn1, e.c1, e.d1, e.v1};
   endfunction

   function automatic logic hits(input ent_t e, input logic [18:0] vpn2, input logic [7:0] asid);
      return (e.vpn2 == vpn2) && (e.g || e.asid == asid);
   endfunction

   // Expected {found, index, pfn, c, d, v} for a search.
   function automatic logic [29:0] ref_search(input logic [31:0] va, input logic [7:0] asid);
      for (int i = 0; i < 16; i++) begin
         if (hits(tbl[i], va[31:13], asid)) begin
            if (va[12])
               return {1'b1, 4'(i), tbl[i].pfn1, tbl[i].c1, tbl[i].d1, tbl[i].v1};
            else
               return {1'b1, 4'(i), tbl[i].pfn0, tbl[i].c0, tbl[i].d0, tbl[i].v0};
         end
      end
      return 30'd0;
   endfunction

   function automatic logic [31:0] ref_probe(input logic [31:0] eh);
      for (int i = 0; i < 16; i++) begin
         if (hits(tbl[i], eh[31:13], eh[7:0])) return 32'(i);
      end
      return 32'h8000_0000;
   endfunction

   function automatic logic [29:0] obs0();
      return {bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v};
   endfunction

   function automatic logic [29:0] obs1();
      return {bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v};
   endfunction

   task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) tbl[i] = mk('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      last0     = '0;
      last1     = '0;
      last_rd   = '0;
      last_pidx = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_s0"}, 78'({bus.s0_rsp, obs0()}), 78'd0);
      chk({tag, "_s1"}, 78'({bus.s1_rsp, obs1()}), 78'd0);
      chk({tag, "_tlbr"}, 78'({bus.tlbr_wen, bus.tlbr_entry}), 78'd0);
      chk({tag, "_tlbp"}, 78'({bus.tlbp_busy, bus.tlbp_done, bus.tlbp_index}), 78'd0);
   endtask

   task automatic search(input logic do0, input logic [31:0] va0, input logic [7:0] as0,
                         input logic do1, input logic [31:0] va1, input logic [7:0] as1,
                         input string tag);
      bus.s0_req = do0; bus.s0_vaddr = va0; bus.s0_asid = as0;
      bus.s1_req = do1; bus.s1_vaddr = va1; bus.s1_asid = as1;
      if (do0) last0 = ref_search(va0, as0);
      if (do1) last1 = ref_search(va1, as1);
      step();
      bus.s0_req = 1'b0;
      bus.s1_req = 1'b0;
      chk({tag, "_rsp0"}, 78'(bus.s0_rsp), 78'(do0));
      chk({tag, "_rsp1"}, 78'(bus.s1_rsp), 78'(do1));
      chk({tag, "_res0"}, 78'(obs0()), 78'(last0));
      chk({tag, "_res1"}, 78'(obs1()), 78'(last1));
   endtask

   task automatic wr(input logic [3:0] idx, input ent_t e);
      bus.tlbwi_we    = 1'b1;
      bus.tlbwi_index = idx;
      bus.tlbwi_entry = pack(e);
      step();
      bus.tlbwi_we = 1'b0;
      tbl[idx]     = e;
   endtask

   task automatic probe(input logic [31:0] eh, input string tag);
      logic [31:0] exp;
      exp              = ref_probe(eh);
      bus.tlbp_req     = 1'b1;
      bus.tlbp_entryhi = eh;
      step();
      bus.tlbp_req = 1'b0;
      chk({tag, "_busy1"}, 78'({bus.tlbp_busy, bus.tlbp_done}), 78'(2'b10));
      step();
      chk({tag, "_done"}, 78'({bus.tlbp_busy, bus.tlbp_done}), 78'(2'b01));
      chk({tag, "_index"}, 78'(bus.tlbp_index), 78'(exp));
      last_pidx = exp;
      step();
      chk({tag, "_after"}, 78'({bus.tlbp_busy, bus.tlbp_done, bus.tlbp_index}), 78'({2'b00, last_pidx}));
   endtask

   function automatic logic [18:0] rand_vpn2();
      case ($urandom_range(0, 3))
         0:       return 19'h12345;
         1:       return 19'h00001;
         2:       return 19'h7FFFF;
         default: return 19'($urandom);
      endcase
   endfunction

   function automatic logic [7:0] rand_asid();
      case ($urandom_range(0, 2))
         0:       return 8'h22;
         1:       return 8'h23;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic ent_t rand_ent();
      return mk(rand_vpn2(), rand_asid(), ($urandom_range(0, 3) == 0),
                20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
   endfunction

   ent_t        e3, e3b, e5;
   logic [29:0] exp0;
   logic [77:0] exp_rd;
   int          dones;

   initial begin
      bus.s0_req = 0; bus.s0_vaddr = '0; bus.s0_asid = '0;
      bus.s1_req = 0; bus.s1_vaddr = '0; bus.s1_asid = '0;
      bus.tlbwi_we = 0; bus.tlbwi_index = '0; bus.tlbwi_entry = '0;
      bus.tlbr_req = 0; bus.tlbr_index = '0;
      bus.tlbp_req = 0; bus.tlbp_entryhi = '0;
      model_reset();

      // Reset state
      step();
      step();
      chk_zero("reset");
      resetn = 1'b1;
      step();

      // Cleared table: address 0 / ASID 0 hits entry 0 with zero fields
      search(1'b1, 32'h0, 8'h00, 1'b0, 32'h0, 8'h00, "zero");
      chk("zero_const", 78'(obs0()), 78'(30'h2000_0000));
      search(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h00, "zero_hold");

      // Asynchronous reset mid-cycle
      bus.s0_req = 1'b1;
      step();
      bus.s0_req = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1 resetn = 1'b1;
      step();

      // Entry 3, odd/even select and ASID mismatch
      e3 = mk(19'h12345, 8'h22, 1'b0, 20'h00100, 3'd0, 1'b0, 1'b1, 20'h00200, 3'd3, 1'b1, 1'b1);
      wr(4'd3, e3);
      search(1'b0, 32'h0, 8'h0, 1'b1, 32'h2468B000, 8'h22, "odd");
      chk("odd_const", 78'(obs1()), 78'({1'b1, 4'd3, 20'h00200, 3'd3, 1'b1, 1'b1}));
      search(1'b0, 32'h0, 8'h0, 1'b1, 32'h2468A000, 8'h22, "even");
      chk("even_const", 78'(obs1()), 78'({1'b1, 4'd3, 20'h00100, 3'd0, 1'b0, 1'b1}));
      search(1'b1, 32'h2468A000, 8'h23, 1'b1, 32'h2468B000, 8'h22, "asid_miss");
      chk("asid_miss_found", 78'(bus.s0_found), 78'd0);

      // Probes against the single-entry table
      probe(32'h2468A022, "probe_hit");
      chk("probe_hit_const", 78'(last_pidx), 78'(32'h0000_0003));
      probe(32'h7FFFE0FF, "probe_miss");
      chk("probe_miss_const", 78'(bus.tlbp_index), 78'(32'h8000_0000));

      // Re-pulsed tlbp_req while busy and in DONE produces a single result
      dones = 0;
      bus.tlbp_req     = 1'b1;
      bus.tlbp_entryhi = 32'h2468A022;
      for (int i = 0; i < 7; i++) begin
         step();
         if (bus.tlbp_done) dones++;
         if (i == 1) bus.tlbp_req = 1'b0;
      end
      chk("probe_single_done", 78'(dones), 78'd1);

      // Global entry and lowest-index priority
      e5 = mk(19'h12345, 8'h99, 1'b1, 20'h0AAAA, 3'd5, 1'b1, 1'b1, 20'h0BBBB, 3'd6, 1'b0, 1'b1);
      wr(4'd5, e5);
      search(1'b1, 32'h2468A000, 8'h23, 1'b1, 32'h2468B000, 8'h22, "global");
      chk("global_idx", 78'(bus.s0_index), 78'd5);
      wr(4'd2, e5);
      search(1'b1, 32'h2468A000, 8'h23, 1'b1, 32'h2468B000, 8'h22, "lowest");
      chk("lowest_idx", 78'({bus.s0_index, bus.s1_index}), 78'({4'd2, 4'd2}));
      probe(32'h2468A022, "probe_lowest");

      // Write and search of the same entry in one cycle
      wr(4'd2, mk('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
      wr(4'd5, mk('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
      e3b = e3;
      e3b.pfn1 = 20'h00ABC;
      exp0 = ref_search(32'h2468B000, 8'h22);
      bus.tlbwi_we = 1'b1; bus.tlbwi_index = 4'd3; bus.tlbwi_entry = pack(e3b);
      bus.s0_req = 1'b1; bus.s0_vaddr = 32'h2468B000; bus.s0_asid = 8'h22;
      step();
      bus.tlbwi_we = 1'b0;
      bus.s0_req   = 1'b0;
      tbl[3] = e3b;
      last0  = exp0;
      chk("wr_search_old", 78'(obs0()), 78'(exp0));
      search(1'b1, 32'h2468B000, 8'h22, 1'b0, 32'h0, 8'h0, "wr_search_new");
      chk("wr_search_new_pfn", 78'(bus.s0_pfn), 78'(20'h00ABC));

      // TLBR
      bus.tlbr_req = 1'b1; bus.tlbr_index = 4'd3;
      step();
      bus.tlbr_req = 1'b0;
      chk("tlbr_wen", 78'(bus.tlbr_wen), 78'd1);
      chk("tlbr_entry", bus.tlbr_entry, pack(e3b));
      step();
      chk("tlbr_hold", 78'({bus.tlbr_wen, bus.tlbr_entry}), 78'(pack(e3b)));
      exp_rd = pack(tbl[3]);
      bus.tlbr_req = 1'b1; bus.tlbr_index = 4'd3;
      bus.tlbwi_we = 1'b1; bus.tlbwi_index = 4'd3; bus.tlbwi_entry = pack(e3);
      step();
      bus.tlbr_req = 1'b0;
      bus.tlbwi_we = 1'b0;
      tbl[3]  = e3;
      last_rd = exp_rd;
      chk("tlbr_wr_old", bus.tlbr_entry, exp_rd);

      // Randomized concurrent traffic
      for (int it = 0; it < 400; it++) begin
         logic        we, r0, r1, rd;
         logic [3:0]  widx, ridx;
         ent_t        went;
         logic [31:0] va0, va1;
         logic [7:0]  as0, as1;
         we   = ($urandom_range(0, 2) == 0);
         r0   = ($urandom_range(0, 1) == 0);
         r1   = ($urandom_range(0, 1) == 0);
         rd   = ($urandom_range(0, 3) == 0);
         widx = 4'($urandom);
         ridx = 4'($urandom);
         went = rand_ent();
         va0  = {rand_vpn2(), 1'($urandom), 12'($urandom)};
         va1  = {rand_vpn2(), 1'($urandom), 12'($urandom)};
         as0  = rand_asid();
         as1  = rand_asid();
         bus.tlbwi_we = we; bus.tlbwi_index = widx; bus.tlbwi_entry = pack(went);
         bus.tlbr_req = rd; bus.tlbr_index = ridx;
         if (rd) last_rd = pack(tbl[ridx]);
         search(r0, va0, as0, r1, va1, as1, "rnd");
         bus.tlbwi_we = 1'b0;
         bus.tlbr_req = 1'b0;
         chk("rnd_tlbr_wen", 78'(bus.tlbr_wen), 78'(rd));
         chk("rnd_tlbr_entry", bus.tlbr_entry, last_rd);
         if (we) tbl[widx] = went;
         if (it % 40 == 39) probe({rand_vpn2(), 5'($urandom), rand_asid()}, "rnd_probe");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- 16-entry fully associative MIPS32 TLB with a fixed 4 KB page mask. It is the responder for the CP0 TLB interface: it executes TLBWI writes, answers TLBR reads, and runs TLBP probes.
- It also serves two registered translation search ports: port 0 (instruction fetch) and port 1 (data access).
- It sits beside the CP0 register block. It is driven by CP0 and by the IF/MEM stages.

Parameters:
- TLBNUM, 16, number of entries.
- IDXW, 4, index width; log2(TLBNUM).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s0_req  in  1  port 0 search request pulse.
- s0_vaddr  in  32  port 0 virtual address.
- s0_asid  in  8  port 0 ASID.
- s0_rsp  out  1  port 0 result valid, one cycle after s0_req.
- s0_found  out  1  port 0 hit.
- s0_index  out  IDXW  port 0 hit index.
- s0_pfn  out  20  port 0 selected PFN.
- s0_c  out  3  port 0 cache attribute.
- s0_d  out  1  port 0 dirty bit.
- s0_v  out  1  port 0 valid bit.
- s1_*  same set as s0_*  port 1 (data).
- tlbwi_we  in  1  write strobe.
- tlbwi_index  in  IDXW  write target.
- tlbwi_entry  in  78  {VPN2[18:0], ASID[7:0], G, PFN0[19:0], C0[2:0], D0, V0, PFN1[19:0], C1[2:0], D1, V1}.
- tlbr_req  in  1  read request pulse.
- tlbr_index  in  IDXW  read source.
- tlbr_wen  out  1  read data valid pulse, to CP0.
- tlbr_entry  out  78  read data, same format as tlbwi_entry.
- tlbp_req  in  1  probe request.
- tlbp_entryhi  in  32  EntryHi: VPN2 in [31:13], ASID in [7:0].
- tlbp_busy  out  1  probe in progress.
- tlbp_done  out  1  probe result pulse.
- tlbp_index  out  32  Index value {P, zeros, idx}.

Behaviour:
- Reset (resetn low, asynchronous):
  - All TLBNUM entries are cleared to 78'b0.
  - All outputs go to 0: s*_rsp, s*_found, s*_index, s*_pfn, s*_c, s*_d, s*_v, tlbr_wen, tlbr_entry, tlbp_busy, tlbp_done, tlbp_index.
  - The probe FSM goes to IDLE.
  - A reset in the middle of a probe aborts it; no tlbp_done is produced.
- Match rule for entry i:
  - VPN2_i == vaddr[31:13], and
  - (G_i or ASID_i == asid).
- Multiple hits: the lowest matching index wins. Result fields are never OR-merged.
- Odd/even select:
  - vaddr[12]=0 selects PFN0/C0/D0/V0.
  - vaddr[12]=1 selects PFN1/C1/D1/V1.
- Search ports:
  - Comparison happens in the s*_req cycle; results are registered at the next edge.
  - s*_rsp is high for exactly one cycle; latency is 1.
  - Result fields hold their value until the next response.
  - On a miss: found=0, index=0, pfn/c/d/v=0.
  - Ports 0 and 1 are independent and may request in the same cycle.
  - Back-to-back requests give back-to-back responses.
- Write:
  - When tlbwi_we is high, the entry at tlbwi_index is replaced at the edge.
  - A search or probe compare in the same cycle sees the pre-write contents.
  - Any later compare cycle sees the new contents.
- Read:
  - tlbr_req latches the entry at tlbr_index; tlbr_entry and tlbr_wen are valid the next cycle.
  - tlbr_wen is a one-cycle pulse; tlbr_entry holds its value afterwards.
  - A read and a write to the same index in the same cycle returns the old value.
- Probe FSM:
  - IDLE:
    - On tlbp_req, latch tlbp_entryhi, set tlbp_busy=1, go to CMP.
  - CMP:
    - Compare the latched VPN2/ASID against all entries using the match rule; odd/even is not used.
    - Register the result and go to DONE.
  - DONE:
    - tlbp_done=1 for this single cycle.
    - tlbp_index = {~hit, (31-IDXW)'b0, hit_idx}; on a miss this is 0x80000000.
    - tlbp_busy drops to 0 in this same cycle. Return to IDLE.
  - tlbp_req is ignored while tlbp_busy=1.
  - A tlbp_req arriving in the DONE cycle is also ignored.
  - Probe latency is req + 2 cycles.
  - tlbp_index holds its value until the next DONE.
- Width rule: tlbp_index bits [30:IDXW] are always 0.

Test Plan:
- Reset, then s0_req with vaddr=0x00000000, asid=0x00 → next cycle s0_rsp=1, found=1, index=0, pfn=0, v=0. Assert resetn low mid-cycle → all outputs 0 immediately.
- tlbwi index=3: VPN2=0x12345, ASID=0x22, G=0, PFN0=0x00100, V0=1, PFN1=0x00200, C1=3, D1=1, V1=1. Then:
  - s1 search vaddr=0x2468B000, asid=0x22 → found=1, index=3, pfn=0x00200, c=3, d=1, v=1.
  - Same search with vaddr=0x2468A000 → pfn=0x00100, d=0, v=1.
- Same address with asid=0x23 → found=0. Write entry 5 with VPN2=0x12345, G=1 → search hits index 5. Write the same entry into index 2 → search hits index 2 (lowest index wins).
- tlbp with entryhi=0x2468A022 against the table from scenario 2 → tlbp_done exactly 2 cycles after tlbp_req, tlbp_index=0x00000003. tlbp with entryhi=0x7FFFE0FF → 0x80000000.
- Re-pulse tlbp_req while tlbp_busy=1 → ignored; only one tlbp_done. tlbwi and s0_req to index 3 in the same cycle → response shows old data; the next search shows new data.
- tlbr index=3 → next cycle tlbr_wen=1 and tlbr_entry equals the written 78-bit value. tlbr and tlbwi on the same index in the same cycle → old value returned.
